clkdiv_multi: RTL

//  Parametrised, run-time programmable clock-enable generator. Replaces fixed counter-bit taps with NUM_CH

---
 rtl/clkdiv_pkg.sv | 9 +
 rtl/clkdiv_if.sv | 16 +
 rtl/clkdiv_channel.sv | 54 +++++
 rtl/clkdiv_multi.sv | 25 ++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and reset-divisor slice helper for the clock-enable generator
package clkdiv_pkg;
  localparam int CNT_W_DEF = 26;
  localparam int DIV_OFF = 0;
  localparam int MAX_PACK = 512;
  function automatic logic [63:0] div_slice(input logic [MAX_PACK-1:0] v, input int i, input int w);
    return 64'(v >> (i * w)) & ((64'd1 << w) - 64'd1);
  endfunction
endpackage

// File: rtl/clkdiv_if.sv
// clkdiv_if: config strobes in (cfg_wr/cfg_sel/cfg_div/align), per-channel tick/sq/cfg_pend out
interface clkdiv_if import clkdiv_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = 3
) ();
  logic cfg_wr;
  logic [SEL_W-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_div;
  logic align;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] cfg_pend;
  modport master (output cfg_wr, cfg_sel, cfg_div, align, input tick, sq, cfg_pend);
  modport slave (input cfg_wr, cfg_sel, cfg_div, align, output tick, sq, cfg_pend);
endinterface

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divide-by-N channel; ports clk, clr, wr/wdata (pending divisor write), align, rst_div -> tick, sq, pend; align honoured only with CLKDIV_ALIGN_EN
module clkdiv_channel import clkdiv_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic wr,
  input  logic align,
  input  logic [CNT_W-1:0] wdata,
  input  logic [CNT_W-1:0] rst_div,
  output logic tick,
  output logic sq,
  output logic pend
);
  logic [CNT_W-1:0] cnt, div_act, div_pend, cnt_nx, div_nx, div_pend_nx;
  logic off, wrap, apply, realign, wr_ok, tick_nx, sq_nx, pend_nx;
`ifdef CLKDIV_ALIGN_EN
  assign realign = align;
`else
  logic unused_align;
  assign unused_align = align;
  assign realign = 1'b0;
`endif
  // a disabled channel restarts at cnt=0 with whatever is pending, like a wrap
  always_comb begin
    off = div_act == CNT_W'(DIV_OFF);
    wrap = !off && cnt == div_act - CNT_W'(1);
    apply = pend && (realign || off || wrap);
    wr_ok = wr && !realign;
    div_nx = apply ? div_pend : div_act;
    cnt_nx = (realign || off || wrap) ? '0 : cnt + CNT_W'(1);
    tick_nx = !realign && wrap;
    sq_nx = !realign && div_nx != CNT_W'(DIV_OFF) && cnt_nx >= (div_nx >> 1);
    pend_nx = wr_ok || (pend && !apply);
    div_pend_nx = wr_ok ? wdata : div_pend;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      div_act <= rst_div;
      div_pend <= '0;
      pend <= 1'b0;
      tick <= 1'b0;
      sq <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      div_act <= div_nx;
      div_pend <= div_pend_nx;
      pend <= pend_nx;
      tick <= tick_nx;
      sq <= sq_nx;
    end
  end
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NUM_CH programmable clock-enable dividers; ports clk, clr, bus (clkdiv_if.slave); optional CLKDIV_ALIGN_EN phase align
module clkdiv_multi import clkdiv_pkg::*; #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SEL_W = 3,
  parameter logic [NUM_CH*CNT_W-1:0] RST_DIV = {26'd33554432, 26'd524288, 26'd4}
) (
  input logic clk,
  input logic clr,
  clkdiv_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .clr(clr),
      .wr(bus.cfg_wr && bus.cfg_sel == SEL_W'(i)),
      .align(bus.align),
      .wdata(bus.cfg_div),
      .rst_div(CNT_W'(div_slice(MAX_PACK'(RST_DIV), i, CNT_W))),
      .tick(bus.tick[i]),
      .sq(bus.sq[i]),
      .pend(bus.cfg_pend[i])
    );
  end
endmodule
